ixmem_stage: RTL and testbench

- EX/MEM stage of the uRISC pipeline.
- Captures each execute-stage result and resolves branches and jumps into a registered fetch redirect plus an ID/EX flush.
- Sequences loads and stores to data memory over a req/ack handshake, stalling upstream while an access is outstanding.
- Presents registered results to writeback.

---
 rtl/ixmem_stage.sv | 159 +++++++++++++++
 tb/tb_ixmem_stage.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ixmem_stage.sv
// EX/MEM pipeline stage: captures execute results, turns taken branches and
// jumps into a one-cycle fetch redirect, and runs loads/stores to data memory
// over a req/ack handshake with a saturating timeout.
module ixmem_stage #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [WIDTH-1:0] alu_output_data,
  input  logic [WIDTH-1:0] pc_nxt_p1,
  input  logic             ex_branch,
  input  logic             ex_jump,
  input  logic             ex_ld,
  input  logic             ex_st,
  input  logic [WIDTH-1:0] ex_st_data,
  input  logic [2:0]       ex_dest_reg,
  input  logic             ex_reg_write,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             ex_stall,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             flush_idix,
  output logic             wb_valid,
  output logic [WIDTH-1:0] wb_data,
  output logic [2:0]       wb_dest_reg,
  output logic             wb_reg_write,
  output logic             mem_err,
  output logic             mem_err_sticky
);

  typedef enum logic {IDLE, MEM_WAIT} state_t;

  localparam logic [TO_W:0]   TO_LIM_X = (TO_W+1)'(MEM_TIMEOUT);
  localparam logic [TO_W-1:0] TO_LIM   = TO_W'(MEM_TIMEOUT);

  state_t           state_q;
  logic [TO_W-1:0]  cnt_q;
  logic             mem_req_q, mem_we_q;
  logic [WIDTH-1:0] mem_addr_q, mem_wdata_q;
  logic [2:0]       acc_dest_q;
  logic             acc_rw_q;
  logic             redirect_valid_q;
  logic [WIDTH-1:0] redirect_pc_q;
  logic             wb_valid_q, wb_reg_write_q;
  logic [WIDTH-1:0] wb_data_q;
  logic [2:0]       wb_dest_reg_q;
  logic             mem_err_q, mem_err_sticky_q;

  logic             accept;
  logic             is_mem;
  logic [TO_W:0]    cnt_inc;

  // Accept decode; a pending redirect marks the EX instruction as wrong-path.
  always_comb begin
    accept  = ex_valid && (state_q == IDLE) && !redirect_valid_q;
    is_mem  = ex_ld || ex_st;
    cnt_inc = {1'b0, cnt_q} + 1'b1;
  end

  // Pipeline registers and IDLE/MEM_WAIT sequencing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      mem_req_q        <= 1'b0;
      mem_we_q         <= 1'b0;
      mem_addr_q       <= '0;
      mem_wdata_q      <= '0;
      acc_dest_q       <= '0;
      acc_rw_q         <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      wb_valid_q       <= 1'b0;
      wb_reg_write_q   <= 1'b0;
      wb_data_q        <= '0;
      wb_dest_reg_q    <= '0;
      mem_err_q        <= 1'b0;
      mem_err_sticky_q <= 1'b0;
    end else begin
      wb_valid_q       <= 1'b0;
      redirect_valid_q <= 1'b0;
      mem_err_q        <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (is_mem) begin
              // Load beats store when both are flagged.
              state_q     <= MEM_WAIT;
              cnt_q       <= '0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= ex_st && !ex_ld;
              mem_addr_q  <= alu_output_data;
              mem_wdata_q <= ex_st_data;
              acc_dest_q  <= ex_dest_reg;
              acc_rw_q    <= ex_ld && ex_reg_write;
            end else begin
              wb_valid_q     <= 1'b1;
              wb_data_q      <= alu_output_data;
              wb_dest_reg_q  <= ex_dest_reg;
              wb_reg_write_q <= (ex_branch && !ex_jump) ? 1'b0 : ex_reg_write;
              if (ex_jump || (ex_branch && alu_output_data[0])) begin
                redirect_valid_q <= 1'b1;
                redirect_pc_q    <= pc_nxt_p1;
              end
            end
          end
        end
        MEM_WAIT: begin
          if (mem_ack) begin
            state_q        <= IDLE;
            mem_req_q      <= 1'b0;
            wb_valid_q     <= 1'b1;
            wb_data_q      <= mem_we_q ? '0 : mem_rdata;
            wb_dest_reg_q  <= acc_dest_q;
            wb_reg_write_q <= acc_rw_q;
          end else if (cnt_inc >= TO_LIM_X) begin
            // Counter reaching the limit on this edge ends the access.
            state_q          <= IDLE;
            cnt_q            <= TO_LIM;
            mem_req_q        <= 1'b0;
            mem_err_q        <= 1'b1;
            mem_err_sticky_q <= 1'b1;
            wb_valid_q       <= 1'b1;
            wb_data_q        <= '0;
            wb_dest_reg_q    <= acc_dest_q;
            wb_reg_write_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_inc[TO_W-1:0];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ex_stall       = (state_q != IDLE);
  assign mem_req        = mem_req_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush_idix     = redirect_valid_q;
  assign wb_valid       = wb_valid_q;
  assign wb_data        = wb_data_q;
  assign wb_dest_reg    = wb_dest_reg_q;
  assign wb_reg_write   = wb_reg_write_q;
  assign mem_err        = mem_err_q;
  assign mem_err_sticky = mem_err_sticky_q;

endmodule

// File: tb/tb_ixmem_stage.sv
// Directed bench for ixmem_stage with MEM_TIMEOUT=4.
module tb_ixmem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_branch, ex_jump, ex_ld, ex_st, ex_reg_write;
  logic [15:0] alu_output_data, pc_nxt_p1, ex_st_data, mem_rdata;
  logic [2:0]  ex_dest_reg;
  logic        mem_ack;
  logic        mem_req, mem_we, ex_stall, redirect_valid, flush_idix;
  logic [15:0] mem_addr, mem_wdata, redirect_pc, wb_data;
  logic        wb_valid, wb_reg_write, mem_err, mem_err_sticky;
  logic [2:0]  wb_dest_reg;

  int checks = 0;
  int errors = 0;

  ixmem_stage #(.WIDTH(16), .MEM_TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .alu_output_data(alu_output_data),
    .pc_nxt_p1(pc_nxt_p1), .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_ld(ex_ld),
    .ex_st(ex_st), .ex_st_data(ex_st_data), .ex_dest_reg(ex_dest_reg),
    .ex_reg_write(ex_reg_write), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .ex_stall(ex_stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush_idix(flush_idix), .wb_valid(wb_valid),
    .wb_data(wb_data), .wb_dest_reg(wb_dest_reg), .wb_reg_write(wb_reg_write),
    .mem_err(mem_err), .mem_err_sticky(mem_err_sticky)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    ex_valid = 0; ex_branch = 0; ex_jump = 0; ex_ld = 0; ex_st = 0;
    ex_reg_write = 0; alu_output_data = '0; pc_nxt_p1 = '0; ex_st_data = '0;
    ex_dest_reg = '0; mem_ack = 0; mem_rdata = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs(); #2;
    checks++; if ({mem_req, ex_stall, wb_valid, redirect_valid, flush_idix, mem_err, mem_err_sticky} !== 7'b0) begin errors++; $display("FAIL reset_flags got %b exp 0000000", {mem_req, ex_stall, wb_valid, redirect_valid, flush_idix, mem_err, mem_err_sticky}); end
    checks++; if ({mem_addr, wb_data, redirect_pc} !== 48'h0) begin errors++; $display("FAIL reset_data got %h exp 0", {mem_addr, wb_data, redirect_pc}); end
    @(negedge clk); rst = 0;
  endtask

  task automatic test_alu(input logic [15:0] val, input logic [2:0] dst);
    @(negedge clk);
    ex_valid = 1; alu_output_data = val; ex_dest_reg = dst; ex_reg_write = 1;
    #1;
    checks++; if (ex_stall !== 1'b0) begin errors++; $display("FAIL alu_stall got %b exp 0", ex_stall); end
    step(); idle_inputs();
    checks++; if (wb_valid !== 1'b1 || wb_data !== val || wb_dest_reg !== dst || wb_reg_write !== 1'b1) begin errors++; $display("FAIL alu_wb got v=%b d=%h r=%0d w=%b exp v=1 d=%h r=%0d w=1", wb_valid, wb_data, wb_dest_reg, wb_reg_write, val, dst); end
    checks++; if (redirect_valid !== 1'b0 || ex_stall !== 1'b0) begin errors++; $display("FAIL alu_noredir got rv=%b st=%b exp 0 0", redirect_valid, ex_stall); end
    step();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL alu_pulse got %b exp 0", wb_valid); end
  endtask

  task automatic test_branch();
    // Taken branch, then a wrong-path op in the following cycle.
    @(negedge clk);
    ex_valid = 1; ex_branch = 1; alu_output_data = 16'h0001; pc_nxt_p1 = 16'h0040; ex_reg_write = 1;
    step();
    idle_inputs(); ex_valid = 1; alu_output_data = 16'h5555; ex_dest_reg = 3'd6; ex_reg_write = 1;
    checks++; if (redirect_valid !== 1'b1 || flush_idix !== 1'b1 || redirect_pc !== 16'h0040) begin errors++; $display("FAIL br_taken got rv=%b fl=%b pc=%h exp 1 1 0040", redirect_valid, flush_idix, redirect_pc); end
    checks++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0) begin errors++; $display("FAIL br_wb got v=%b w=%b exp 1 0", wb_valid, wb_reg_write); end
    step(); idle_inputs();
    checks++; if (wb_valid !== 1'b0 || redirect_valid !== 1'b0 || flush_idix !== 1'b0) begin errors++; $display("FAIL br_wrongpath got v=%b rv=%b fl=%b exp 0 0 0", wb_valid, redirect_valid, flush_idix); end
    // Not-taken branch.
    @(negedge clk);
    ex_valid = 1; ex_branch = 1; alu_output_data = 16'h0000; pc_nxt_p1 = 16'h0080;
    step(); idle_inputs();
    checks++; if (redirect_valid !== 1'b0 || wb_valid !== 1'b1) begin errors++; $display("FAIL br_nottaken got rv=%b v=%b exp 0 1", redirect_valid, wb_valid); end
    // JAL: redirect plus link writeback.
    @(negedge clk);
    ex_valid = 1; ex_jump = 1; alu_output_data = 16'h0022; pc_nxt_p1 = 16'h0090; ex_dest_reg = 3'd7; ex_reg_write = 1;
    step(); idle_inputs();
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 16'h0090) begin errors++; $display("FAIL jal_redir got rv=%b pc=%h exp 1 0090", redirect_valid, redirect_pc); end
    checks++; if (wb_valid !== 1'b1 || wb_data !== 16'h0022 || wb_reg_write !== 1'b1 || wb_dest_reg !== 3'd7) begin errors++; $display("FAIL jal_link got v=%b d=%h w=%b r=%0d exp 1 0022 1 7", wb_valid, wb_data, wb_reg_write, wb_dest_reg); end
    step();
  endtask

  task automatic test_load();
    int req_cycles = 0;
    @(negedge clk);
    ex_valid = 1; ex_ld = 1; alu_output_data = 16'h0100; ex_dest_reg = 3'd5; ex_reg_write = 1;
    #1;
    checks++; if (ex_stall !== 1'b0) begin errors++; $display("FAIL ld_accept_stall got %b exp 0", ex_stall); end
    step(); idle_inputs();
    for (int i = 0; i < 3; i++) begin
      if (mem_req === 1'b1) req_cycles++;
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0100 || ex_stall !== 1'b1) begin errors++; $display("FAIL ld_wait%0d got req=%b we=%b a=%h st=%b exp 1 0 0100 1", i, mem_req, mem_we, mem_addr, ex_stall); end
      mem_ack = (i == 2); mem_rdata = 16'hBEEF;
      step();
    end
    mem_ack = 0; mem_rdata = '0;
    checks++; if (mem_req !== 1'b0 || ex_stall !== 1'b0 || req_cycles != 3) begin errors++; $display("FAIL ld_done got req=%b st=%b n=%0d exp 0 0 3", mem_req, ex_stall, req_cycles); end
    checks++; if (wb_valid !== 1'b1 || wb_data !== 16'hBEEF || wb_dest_reg !== 3'd5 || wb_reg_write !== 1'b1) begin errors++; $display("FAIL ld_wb got v=%b d=%h r=%0d w=%b exp 1 beef 5 1", wb_valid, wb_data, wb_dest_reg, wb_reg_write); end
    step();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL ld_pulse got %b exp 0", wb_valid); end
  endtask

  task automatic test_store(input int ack_cycle);
    @(negedge clk);
    ex_valid = 1; ex_st = 1; alu_output_data = 16'h0200; ex_st_data = 16'hAAAA; ex_reg_write = 1;
    step(); idle_inputs();
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 16'hAAAA || mem_err !== 1'b0) begin errors++; $display("FAIL st_wait%0d got req=%b we=%b wd=%h err=%b exp 1 1 aaaa 0", i, mem_req, mem_we, mem_wdata, mem_err); end
      mem_ack = (i == ack_cycle);
      step();
    end
    mem_ack = 0;
    checks++; if (mem_req !== 1'b0 || ex_stall !== 1'b0 || wb_valid !== 1'b1 || wb_reg_write !== 1'b0) begin errors++; $display("FAIL st_end got req=%b st=%b v=%b w=%b exp 0 0 1 0", mem_req, ex_stall, wb_valid, wb_reg_write); end
    if (ack_cycle < 0) begin
      checks++; if (mem_err !== 1'b1 || mem_err_sticky !== 1'b1) begin errors++; $display("FAIL st_timeout got err=%b sticky=%b exp 1 1", mem_err, mem_err_sticky); end
    end else begin
      checks++; if (mem_err !== 1'b0 || wb_data !== 16'h0000) begin errors++; $display("FAIL st_ack got err=%b d=%h exp 0 0000", mem_err, wb_data); end
    end
    step();
    checks++; if (mem_err !== 1'b0 || mem_err_sticky !== 1'b1) begin errors++; $display("FAIL st_after got err=%b sticky=%b exp 0 1", mem_err, mem_err_sticky); end
  endtask

  task automatic test_idle_ack();
    @(negedge clk); mem_ack = 1; mem_rdata = 16'h7777;
    step(); mem_ack = 0;
    checks++; if (wb_valid !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL idle_ack got v=%b req=%b exp 0 0", wb_valid, mem_req); end
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    ex_valid = 1; ex_ld = 1; alu_output_data = 16'h0300; ex_reg_write = 1;
    step(); idle_inputs();
    step();
    checks++; if (mem_req !== 1'b1 || ex_stall !== 1'b1) begin errors++; $display("FAIL rst_pre got req=%b st=%b exp 1 1", mem_req, ex_stall); end
    #2 rst = 1; #1;
    checks++; if ({mem_req, ex_stall, wb_valid, mem_err_sticky} !== 4'b0) begin errors++; $display("FAIL rst_mid got %b exp 0000", {mem_req, ex_stall, wb_valid, mem_err_sticky}); end
    @(negedge clk); rst = 0;
    step();
    checks++; if (wb_valid !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL rst_nowb got v=%b req=%b exp 0 0", wb_valid, mem_req); end
  endtask

  initial begin
    test_reset();
    test_alu(16'h1234, 3'd3);
    test_branch();
    test_load();
    test_store(-1);
    test_store(3);
    test_idle_ack();
    test_reset_mid_access();
    test_alu(16'hA5C3, 3'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
